// File: rtl/generator_sched.sv
// Round-robin scheduler that lends one shared generator counter to NREQ requesters,
// one burst at a time, forwarding each count value to the granted requester.
module generator_sched #(
   parameter int NREQ  = 2,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LEN_W-1:0]   req_len,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done,
   output logic                    out_valid,
   output logic [CNT_W-1:0]        out_data,
   input  logic                    out_ready,
   output logic                    gen_res,
   output logic                    gen_en,
   input  logic [CNT_W-1:0]        gen_count
);

   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr, rr_nxt;
   logic [ID_W-1:0]  id, id_nxt;
   logic [LEN_W-1:0] rem, rem_nxt;

   logic             found;
   logic [ID_W-1:0]  pick;
   logic [ID_W:0]    cand;
   logic [NREQ-1:0]  id_oh;

   // Search upward from the round-robin pointer, wrapping modulo NREQ; first hit wins.
   always_comb begin : arbiter
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      found = 1'b0;
      pick  = rr;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NREQ)) begin
            cand = cand - (ID_W+1)'(NREQ);
         end
         if (!found && req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      rr_nxt    = rr;
      id_nxt    = id;
      rem_nxt   = rem;
      case (state)
         IDLE: begin
            if (found) begin
               id_nxt    = pick;
               rem_nxt   = req_len[pick*LEN_W +: LEN_W];
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            state_nxt = (rem != '0) ? RUN : DONE;
         end
         RUN: begin
            // out_valid is always high here, so out_ready alone marks a transfer.
            if (out_ready) begin
               rem_nxt = rem - LEN_W'(1);
               if (rem == LEN_W'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            rr_nxt    = (id == ID_W'(NREQ-1)) ? '0 : id + ID_W'(1);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : regs
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (res) begin
         state <= IDLE;
         rr    <= '0;
         id    <= '0;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
         id    <= id_nxt;
         rem   <= rem_nxt;
      end
   end

   always_comb begin : outputs
      id_oh     = NREQ'(1) << id;
      grant     = (state != IDLE) ? id_oh : '0;
      done      = (state == DONE) ? id_oh : '0;
      out_valid = (state == RUN);
      out_data  = (state == RUN) ? gen_count : '0;
      // The generator is cleared both by our own reset and once per burst in CLEAR.
      gen_res   = res | (state == CLEAR);
      gen_en    = (state == RUN) & out_ready & ~res;
   end

endmodule

// File: tb/tb_generator_sched.sv
// Directed bench for generator_sched: a behavioural generator model, a table of
// back-to-back bursts, and hand sequences for back-pressure, mid-burst reset and request drop.
module tb_generator_sched;

   localparam int NREQ  = 2;
   localparam int LEN_W = 4;
   localparam int CNT_W = 8;

   logic                  clk = 1'b0;
   logic                  res;
   logic [NREQ-1:0]       req;
   logic [NREQ*LEN_W-1:0] req_len;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  out_valid;
   logic [CNT_W-1:0]      out_data;
   logic                  out_ready;
   logic                  gen_res;
   logic                  gen_en;
   logic [CNT_W-1:0]      gen_count;

   int n_cmp = 0;
   int n_bad = 0;

   generator_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .res       (res),
      .req       (req),
      .req_len   (req_len),
      .grant     (grant),
      .done      (done),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .gen_res   (gen_res),
      .gen_en    (gen_en),
      .gen_count (gen_count)
   );

   always #5 clk = ~clk;

   // Behavioural generator following its published contract.
   always_ff @(posedge clk) begin
      if (gen_res)     gen_count <= '0;
      else if (gen_en) gen_count <= gen_count + 8'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Observe one whole burst starting from an IDLE negedge. Optionally stall the
   // consumer when stall_val first appears, and/or drop req when drop_val appears.
   task automatic run_burst(input string tag, input int exp_id, input int exp_len,
                            input int stall_val, input int stall_n, input int drop_val);
      int wait_cnt = 0;
      int gcyc = 0, xfers = 0, dones = 0, gres = 0, stalls = stall_n;
      int bad_grant = 0, bad_val = 0, bad_done = 0, bad_stall = 0;
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << exp_id;
      @(negedge clk);
      while (grant == '0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (grant == '0) begin
         check({tag, "_grant_timeout"}, 0, 1);
         return;
      end
      while (grant != '0 && gcyc < 300) begin
         gcyc++;
         if (grant != oh) bad_grant++;
         if (gen_res) gres++;
         if (done != '0) begin
            dones++;
            if (done != oh) bad_done++;
         end
         if (out_valid && stalls > 0 && int'(out_data) == stall_val) begin
            out_ready = 1'b0;
            stalls--;
            #1;
            if (int'(out_data) != stall_val || !out_valid || gen_en) bad_stall++;
         end else begin
            out_ready = 1'b1;
            #1;
         end
         if (drop_val >= 0 && out_valid && int'(out_data) == drop_val) req = '0;
         if (out_valid && out_ready) begin
            if (int'(out_data) != xfers) bad_val++;
            xfers++;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      check({tag, "_grant_cycles"}, gcyc, exp_len + 2 + stall_n);
      check({tag, "_transfers"}, xfers, exp_len);
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_gen_res_cycles"}, gres, 1);
      check({tag, "_grant_onehot_errs"}, bad_grant + bad_done, 0);
      check({tag, "_data_seq_errs"}, bad_val, 0);
      if (stall_n > 0) begin
         check({tag, "_stall_hold_errs"}, bad_stall, 0);
         check({tag, "_stalls_applied"}, stalls, 0);
      end
   endtask

   typedef struct {
      logic [1:0] req;
      logic [3:0] len0;
      logic [3:0] len1;
      int         exp_id;
      int         exp_len;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int cnt, n;
      res       = 1'b1;
      req       = '0;
      req_len   = '0;
      out_ready = 1'b1;

      // Rows run back to back; each expectation follows from the rr pointer left by the row before.
      vecs[0] = '{2'b01, 4'd5,  4'd0, 0, 5};
      vecs[1] = '{2'b10, 4'd9,  4'd0, 1, 0};
      vecs[2] = '{2'b11, 4'd3,  4'd2, 0, 3};
      vecs[3] = '{2'b11, 4'd3,  4'd2, 1, 2};
      vecs[4] = '{2'b11, 4'd3,  4'd2, 0, 3};
      vecs[5] = '{2'b10, 4'd6,  4'd1, 1, 1};
      vecs[6] = '{2'b11, 4'd15, 4'd7, 0, 15};
      vecs[7] = '{2'b11, 4'd15, 4'd7, 1, 7};

      @(negedge clk);
      @(negedge clk);
      check("rst_grant", int'(grant), 0);
      check("rst_done", int'(done), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_gen_en", int'(gen_en), 0);
      check("rst_gen_res", int'(gen_res), 1);
      res = 1'b0;
      #1;
      check("idle_gen_res", int'(gen_res), 0);

      for (int i = 0; i < 8; i++) begin
         req     = vecs[i].req;
         req_len = {vecs[i].len1, vecs[i].len0};
         run_burst($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_len, -1, 0, -1);
      end

      // Back-pressure: hold the consumer off for 3 cycles while value 1 is presented.
      req     = 2'b01;
      req_len = {4'd0, 4'd4};
      run_burst("bp", 0, 4, 1, 3, -1);

      // Mid-burst reset on requester 1; afterwards arbitration must restart at 0.
      req     = 2'b10;
      req_len = {4'd8, 4'd0};
      cnt = 0;
      n   = 0;
      while (cnt < 3 && n < 40) begin
         @(negedge clk);
         n++;
         if (out_valid) cnt++;
      end
      check("midrst_reach_run3", cnt, 3);
      res = 1'b1;
      @(negedge clk);
      check("midrst_grant", int'(grant), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_gen_res", int'(gen_res), 1);
      res     = 1'b0;
      req     = 2'b11;
      req_len = {4'd2, 4'd2};
      run_burst("post_rst", 0, 2, -1, 0, -1);

      // Requester 0 drops req during RUN; the burst must still complete in full.
      req     = 2'b01;
      req_len = {4'd0, 4'd6};
      run_burst("drop", 0, 6, -1, 0, 2);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (grant != '0) cnt++;
      end
      check("drop_idle_after", cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
